// File: rtl/multiplier_if.sv
// Request/response handshake bundle for the iterative multiplier.
// The master issues operands and accepts products; the slave is the multiplier.
interface multiplier_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   req_msg_a;
  logic [WIDTH-1:0]   req_msg_b;
  logic               req_val;
  logic               req_rdy;
  logic [2*WIDTH-1:0] resp_msg;
  logic               resp_val;
  logic               resp_rdy;

  modport master (
    output req_msg_a, req_msg_b, req_val, resp_rdy,
    input  req_rdy, resp_msg, resp_val
  );

  modport slave (
    input  req_msg_a, req_msg_b, req_val, resp_rdy,
    output req_rdy, resp_msg, resp_val
  );
endinterface

// File: rtl/multiplier.sv
// Radix-2 shift-and-add unsigned multiplier, one operand bit per cycle.
// A request is accepted in IDLE, iterated WIDTH times in CALC, and held in DONE until consumed.
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] aReg_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] accSum_d;
  logic [WIDTH-1:0]   bReg_q;
  logic [CW-1:0]      cnt_q;
  logic               reqRdy_q;
  logic               respVal_q;

  assign accSum_d = bReg_q[0] ? (acc_q + aReg_q) : acc_q;

  // Handshake outputs are registered alongside the state, so neither ready nor
  // valid has a combinational path from the opposite side of the interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aReg_q    <= '0;
      bReg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      reqRdy_q  <= 1'b1;
      respVal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_val && reqRdy_q) begin
            aReg_q   <= {{WIDTH{1'b0}}, bus.req_msg_a};
            bReg_q   <= bus.req_msg_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            reqRdy_q <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q  <= accSum_d;
          aReg_q <= aReg_q << 1;
          bReg_q <= bReg_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            respVal_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_rdy) begin
            respVal_q <= 1'b0;
            reqRdy_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          respVal_q <= 1'b0;
          reqRdy_q  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_rdy  = reqRdy_q;
  assign bus.resp_val = respVal_q;
  assign bus.resp_msg = acc_q;
endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the iterative multiplier: directed vectors, random
// operands against plain 64-bit multiplication, backpressure, reset abort, throughput.
module tb_multiplier;
  localparam int WIDTH = 32;
  localparam int LATENCY = WIDTH + 1;
  localparam int PERIOD = WIDTH + 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] expected;
  } vector_t;

  logic clk;
  logic rst;
  int checks;
  int errors;

  multiplier_if #(.WIDTH(WIDTH)) bus ();

  multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Runs one operation starting from an IDLE negedge; scrambles operands while in flight.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               output logic [63:0] result, output int latency);
    bus.req_msg_a = a;
    bus.req_msg_b = b;
    bus.req_val   = 1'b1;
    latency = 0;
    result  = '0;
    do begin
      @(negedge clk);
      latency++;
      if (latency == 1) begin
        bus.req_val   = 1'b0;
        bus.req_msg_a = $urandom;
        bus.req_msg_b = $urandom;
        checkOutput("busy_req_rdy", 64'(bus.req_rdy), 64'd0);
      end
    end while (!bus.resp_val && latency < 200);
    result = bus.resp_msg;
  endtask

  vector_t vectors[$];
  logic [63:0] result;
  logic [63:0] held;
  logic [63:0] expected;
  logic [31:0] ra;
  logic [31:0] rb;
  int latency;
  int sawResp;
  int firstResp;
  int secondResp;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_msg_a = '0;
    bus.req_msg_b = '0;
    bus.req_val   = 1'b0;
    bus.resp_rdy  = 1'b1;

    vectors.push_back('{32'd1, 32'd1, 64'h1});
    vectors.push_back('{32'd100, 32'd100, 64'h2710});
    vectors.push_back('{32'd65536, 32'd65536, 64'h0000_0001_0000_0000});
    vectors.push_back('{32'd256, 32'd1024, 64'h40000});
    vectors.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001});
    vectors.push_back('{32'hFFFFFFFF, 32'h0000FFFF, 64'h0000FFFE_FFFF0001});
    vectors.push_back('{32'hFFFFFFFF, 32'h0000000F, 64'h0000000E_FFFFFFF1});
    vectors.push_back('{32'd0, 32'hDEADBEEF, 64'h0});
    vectors.push_back('{32'h12345678, 32'd0, 64'h0});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_req_rdy", 64'(bus.req_rdy), 64'd1);
    checkOutput("reset_resp_val", 64'(bus.resp_val), 64'd0);
    checkOutput("reset_resp_msg", bus.resp_msg, 64'd0);

    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i].a, vectors[i].b, result, latency);
      checkOutput($sformatf("vec%0d_latency", i), 64'(latency), 64'(LATENCY));
      checkOutput($sformatf("vec%0d_product", i), result, vectors[i].expected);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_idle_rdy", i), 64'(bus.req_rdy), 64'd1);
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h8000_0000;
      expected = 64'(ra) * 64'(rb);
      applyStimulus(ra, rb, result, latency);
      checkOutput($sformatf("rand%0d_product", i), result, expected);
      @(negedge clk);
    end

    // Backpressure: result must hold while the consumer stalls.
    bus.resp_rdy = 1'b0;
    applyStimulus(32'd7, 32'd9, result, latency);
    checkOutput("bp_product", result, 64'd63);
    held = bus.resp_msg;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_resp_val", 64'(bus.resp_val), 64'd1);
      checkOutput("bp_resp_msg", bus.resp_msg, held);
      checkOutput("bp_req_rdy", 64'(bus.req_rdy), 64'd0);
    end
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_req_rdy", 64'(bus.req_rdy), 64'd1);
    checkOutput("bp_release_resp_val", 64'(bus.resp_val), 64'd0);

    // Reset during CALC aborts the operation with no response.
    bus.req_msg_a = 32'd11;
    bus.req_msg_b = 32'd13;
    bus.req_val   = 1'b1;
    @(negedge clk);
    bus.req_val = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_req_rdy", 64'(bus.req_rdy), 64'd1);
    checkOutput("abort_resp_val", 64'(bus.resp_val), 64'd0);
    sawResp = 0;
    repeat (2 * PERIOD) begin
      @(negedge clk);
      if (bus.resp_val) sawResp = 1;
    end
    checkOutput("abort_no_resp", 64'(sawResp), 64'd0);

    // Back-to-back with req_val and resp_rdy held high.
    bus.req_msg_a = 32'd3;
    bus.req_msg_b = 32'd5;
    bus.req_val   = 1'b1;
    firstResp  = -1;
    secondResp = -1;
    for (int c = 1; c <= 4 * PERIOD && secondResp < 0; c++) begin
      @(negedge clk);
      if (bus.resp_val) begin
        checkOutput("b2b_product", bus.resp_msg, 64'd15);
        if (firstResp < 0) firstResp = c;
        else secondResp = c;
      end
    end
    bus.req_val = 1'b0;
    checkOutput("b2b_first_latency", 64'(firstResp), 64'(LATENCY));
    checkOutput("b2b_period", 64'(secondResp - firstResp), 64'(PERIOD));
    repeat (PERIOD + 2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
